// File: rtl/btb_upd_queue.sv
// rtl/btb_upd_queue.sv - retire-to-BTB update queue with allocate-port arbitration
// Buffers resolved branches and turns each into BTB allocate and/or direction writes.
module btb_upd_queue #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rt_valid_i,
  output logic        rt_ready_o,
  input  logic [63:0] rt_brpc_i,
  input  logic [63:0] rt_brtar_i,
  input  logic [1:0]  rt_brtyp_i,
  input  logic [2:0]  rt_brpos_i,
  input  logic        rt_taken_i,
  input  logic        rt_btbhit_i,
  input  logic        rt_tarmis_i,
  input  logic        f1_we_i,
  input  logic [2:0]  f1_brpos_i,
  input  logic [1:0]  f1_brtyp_i,
  input  logic [63:0] f1_brpc_i,
  input  logic [63:0] f1_brtar_i,
  output logic        f1_drop_o,
  output logic        btb_sp_we_o,
  output logic [2:0]  btb_sp_brpos_o,
  output logic [1:0]  btb_sp_brtyp_o,
  output logic [63:0] btb_sp_brpc_o,
  output logic [63:0] btb_sp_brtar_o,
  output logic [1:0]  btb_ras_ctl_o,
  output logic        btb_rt_we_o,
  output logic        btb_rt_brdir_o,
  output logic [63:0] btb_rt_brpc_o,
  output logic        empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] tar;
    logic [1:0]  typ;
    logic [2:0]  pos;
    logic        taken;
    logic        hit;
    logic        tarmis;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_DIR} state_t;

  function automatic logic [1:0] ras_of(input logic [1:0] typ);
    case (typ)
      2'b10:   ras_of = 2'b01;
      2'b11:   ras_of = 2'b10;
      default: ras_of = 2'b00;
    endcase
  endfunction

  rec_t          mem_q [DEPTH];
  rec_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          push, pop, alloc_gnt, dir_wr, need_alloc, need_dir;
  logic          empty_q;

  assign head       = mem_q[rd_ptr_q];
  assign need_alloc = head.taken && (!head.hit || head.tarmis);
  assign need_dir   = (head.typ == 2'b00) && (head.hit || need_alloc);
  assign rt_ready_o = (count_q != CNT_FULL);
  assign push       = rt_valid_i && rt_ready_o;
  assign f1_drop_o  = (state_q == S_ALLOC) && f1_we_i && (starve_q == STARVE_LIM);
  assign empty_o    = empty_q;
  assign count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    alloc_gnt = 1'b0;
    dir_wr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (need_alloc)    state_d = S_ALLOC;
          else if (need_dir) state_d = S_DIR;
          else               pop     = 1'b1;
        end
      end
      S_ALLOC: begin
        if (!f1_we_i || starve_q == STARVE_LIM) begin
          alloc_gnt = 1'b1;
          if (head.typ == 2'b00) begin
            state_d = S_DIR;
          end else begin
            pop     = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DIR: begin
        dir_wr  = 1'b1;
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter only advances while a queued allocation is losing to fetch1.
  assign starve_d = (state_q == S_ALLOC && f1_we_i && !alloc_gnt) ? starve_q + SW'(1) : '0;

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{rt_brpc_i, rt_brtar_i, rt_brtyp_i, rt_brpos_i,
                                   rt_taken_i, rt_btbhit_i, rt_tarmis_i};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= S_IDLE;
      starve_q       <= '0;
      empty_q        <= 1'b1;
      btb_sp_we_o    <= 1'b0;
      btb_sp_brpos_o <= '0;
      btb_sp_brtyp_o <= '0;
      btb_sp_brpc_o  <= '0;
      btb_sp_brtar_o <= '0;
      btb_ras_ctl_o  <= '0;
      btb_rt_we_o    <= 1'b0;
      btb_rt_brdir_o <= 1'b0;
      btb_rt_brpc_o  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      state_q     <= state_d;
      starve_q    <= starve_d;
      empty_q     <= (count_d == '0);
      btb_sp_we_o <= alloc_gnt || f1_we_i;
      if (alloc_gnt) begin
        btb_sp_brpos_o <= head.pos;
        btb_sp_brtyp_o <= head.typ;
        btb_sp_brpc_o  <= head.pc;
        btb_sp_brtar_o <= head.tar;
        btb_ras_ctl_o  <= ras_of(head.typ);
      end else if (f1_we_i) begin
        btb_sp_brpos_o <= f1_brpos_i;
        btb_sp_brtyp_o <= f1_brtyp_i;
        btb_sp_brpc_o  <= f1_brpc_i;
        btb_sp_brtar_o <= f1_brtar_i;
        btb_ras_ctl_o  <= ras_of(f1_brtyp_i);
      end
      btb_rt_we_o <= dir_wr;
      if (dir_wr) begin
        btb_rt_brdir_o <= head.taken;
        btb_rt_brpc_o  <= head.pc;
      end
    end
  end
endmodule

// File: tb/tb_btb_upd_queue.sv
// tb/tb_btb_upd_queue.sv - randomized model-checked bench for btb_upd_queue
// Directed scenarios pin the model with literal timing; random traffic then runs against it.
module tb_btb_upd_queue;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clock, reset;
  logic        rt_valid_i, rt_ready_o, rt_taken_i, rt_btbhit_i, rt_tarmis_i;
  logic [63:0] rt_brpc_i, rt_brtar_i, f1_brpc_i, f1_brtar_i;
  logic [1:0]  rt_brtyp_i, f1_brtyp_i;
  logic [2:0]  rt_brpos_i, f1_brpos_i;
  logic        f1_we_i, f1_drop_o;
  logic        btb_sp_we_o, btb_rt_we_o, btb_rt_brdir_o, empty_o;
  logic [2:0]  btb_sp_brpos_o;
  logic [1:0]  btb_sp_brtyp_o, btb_ras_ctl_o;
  logic [63:0] btb_sp_brpc_o, btb_sp_brtar_o, btb_rt_brpc_o;

  btb_upd_queue #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .rt_valid_i(rt_valid_i), .rt_ready_o(rt_ready_o), .rt_brpc_i(rt_brpc_i),
    .rt_brtar_i(rt_brtar_i), .rt_brtyp_i(rt_brtyp_i), .rt_brpos_i(rt_brpos_i),
    .rt_taken_i(rt_taken_i), .rt_btbhit_i(rt_btbhit_i), .rt_tarmis_i(rt_tarmis_i),
    .f1_we_i(f1_we_i), .f1_brpos_i(f1_brpos_i), .f1_brtyp_i(f1_brtyp_i),
    .f1_brpc_i(f1_brpc_i), .f1_brtar_i(f1_brtar_i), .f1_drop_o(f1_drop_o),
    .btb_sp_we_o(btb_sp_we_o), .btb_sp_brpos_o(btb_sp_brpos_o),
    .btb_sp_brtyp_o(btb_sp_brtyp_o), .btb_sp_brpc_o(btb_sp_brpc_o),
    .btb_sp_brtar_o(btb_sp_brtar_o), .btb_ras_ctl_o(btb_ras_ctl_o),
    .btb_rt_we_o(btb_rt_we_o), .btb_rt_brdir_o(btb_rt_brdir_o),
    .btb_rt_brpc_o(btb_rt_brpc_o), .empty_o(empty_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] tar;
    logic [1:0]  typ;
    logic [2:0]  pos;
    logic        taken;
    logic        hit;
    logic        tarmis;
  } rec_t;

  int vectors = 0;
  int miscompares = 0;

  rec_t m_q[$];
  int   m_stage;
  int   m_starve;
  logic e_sp_we, e_rt_we, e_rt_dir, e_empty;
  logic [2:0]  e_sp_pos;
  logic [1:0]  e_sp_typ, e_ras;
  logic [63:0] e_sp_pc, e_sp_tar, e_rt_pc;
  logic last_drop;

  int w_first_sp, w_first_rt, w_nsp, w_nrt, w_tgt, w_ndrop, w_nseen;
  logic [1:0]  w_ras;
  logic        w_dir;
  logic [63:0] w_seen [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stage = 0; m_starve = 0;
    e_sp_we = 0; e_rt_we = 0; e_rt_dir = 0; e_empty = 1;
    e_sp_pos = 0; e_sp_typ = 0; e_ras = 0; e_sp_pc = 0; e_sp_tar = 0; e_rt_pc = 0;
  endtask

  function automatic logic [1:0] ras_for(input logic [1:0] typ);
    return (typ == 2) ? 2'd1 : (typ == 3) ? 2'd2 : 2'd0;
  endfunction

  // Stage 0: head awaiting classification, 1: head waiting for the allocate port,
  // 2: head owes its direction write.
  task automatic model_edge();
    rec_t h, r;
    bit have, grant, dirw, popq, pushq;
    int nstage;
    have  = (m_q.size() > 0);
    if (have) h = m_q[0];
    pushq = rt_valid_i && (m_q.size() != DEPTH);
    grant = 0; dirw = 0; popq = 0; nstage = m_stage;
    if (m_stage == 0 && have) begin
      if (h.taken && (!h.hit || h.tarmis)) nstage = 1;
      else if (h.typ == 0 && h.hit)        nstage = 2;
      else                                 popq = 1;
    end else if (m_stage == 1) begin
      if (!f1_we_i || m_starve == STARVE_MAX) begin
        grant = 1;
        if (h.typ == 0) nstage = 2;
        else begin nstage = 0; popq = 1; end
      end
    end else if (m_stage == 2) begin
      dirw = 1; popq = 1; nstage = 0;
    end
    if (grant) begin
      e_sp_we = 1; e_sp_pos = h.pos; e_sp_typ = h.typ; e_sp_pc = h.pc; e_sp_tar = h.tar;
      e_ras = ras_for(h.typ);
    end else if (f1_we_i) begin
      e_sp_we = 1; e_sp_pos = f1_brpos_i; e_sp_typ = f1_brtyp_i; e_sp_pc = f1_brpc_i;
      e_sp_tar = f1_brtar_i; e_ras = ras_for(f1_brtyp_i);
    end else e_sp_we = 0;
    e_rt_we = dirw;
    if (dirw) begin e_rt_dir = h.taken; e_rt_pc = h.pc; end
    m_starve = (m_stage == 1 && !grant && f1_we_i) ? m_starve + 1 : 0;
    if (popq) void'(m_q.pop_front());
    if (pushq) begin
      r = '{rt_brpc_i, rt_brtar_i, rt_brtyp_i, rt_brpos_i, rt_taken_i, rt_btbhit_i, rt_tarmis_i};
      m_q.push_back(r);
    end
    e_empty = (m_q.size() == 0);
    m_stage = nstage;
  endtask

  task automatic tick();
    #1;
    last_drop = f1_drop_o;
    chk("rt_ready", rt_ready_o, m_q.size() != DEPTH);
    chk("f1_drop", f1_drop_o, m_stage == 1 && f1_we_i && m_starve == STARVE_MAX);
    model_edge();
    @(posedge clock);
    @(negedge clock);
    chk("sp_we", btb_sp_we_o, e_sp_we);
    chk("sp_brpos", btb_sp_brpos_o, e_sp_pos);
    chk("sp_brtyp", btb_sp_brtyp_o, e_sp_typ);
    chk("sp_brpc", btb_sp_brpc_o, e_sp_pc);
    chk("sp_brtar", btb_sp_brtar_o, e_sp_tar);
    chk("ras_ctl", btb_ras_ctl_o, e_ras);
    chk("rt_we", btb_rt_we_o, e_rt_we);
    chk("rt_brdir", btb_rt_brdir_o, e_rt_dir);
    chk("rt_brpc", btb_rt_brpc_o, e_rt_pc);
    chk("empty", empty_o, e_empty);
  endtask

  task automatic watch(input int n, input logic [63:0] tgt);
    w_first_sp = -1; w_first_rt = -1; w_nsp = 0; w_nrt = 0; w_tgt = -1; w_ndrop = 0;
    w_nseen = 0; w_ras = 0; w_dir = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (last_drop) w_ndrop++;
      if (btb_sp_we_o) begin
        w_nsp++;
        if (w_first_sp < 0) begin w_first_sp = i; w_ras = btb_ras_ctl_o; end
        if (btb_sp_brpc_o == tgt && w_tgt < 0) w_tgt = i;
        if (w_nseen < 8) begin w_seen[w_nseen] = btb_sp_brpc_o; w_nseen++; end
      end
      if (btb_rt_we_o) begin
        w_nrt++;
        if (w_first_rt < 0) begin w_first_rt = i; w_dir = btb_rt_brdir_o; end
      end
    end
  endtask

  task automatic set_rec(input logic [63:0] pc, input logic [63:0] tar, input logic [1:0] typ,
                         input logic taken, input logic hit, input logic tarmis);
    rt_brpc_i = pc; rt_brtar_i = tar; rt_brtyp_i = typ; rt_brpos_i = 3'($urandom_range(0, 7));
    rt_taken_i = taken; rt_btbhit_i = hit; rt_tarmis_i = tarmis;
  endtask

  task automatic push_one(input logic [63:0] pc, input logic [1:0] typ,
                          input logic taken, input logic hit, input logic tarmis);
    set_rec(pc, pc + 64'h1000, typ, taken, hit, tarmis);
    rt_valid_i = 1; tick(); rt_valid_i = 0;
  endtask

  task automatic rand_f1(input int pct);
    f1_we_i    = ($urandom_range(0, 99) < pct);
    f1_brpos_i = 3'($urandom_range(0, 7));
    f1_brtyp_i = 2'($urandom_range(0, 3));
    f1_brpc_i  = {$urandom, $urandom};
    f1_brtar_i = {$urandom, $urandom};
  endtask

  initial begin
    reset = 1; rt_valid_i = 0; f1_we_i = 0;
    set_rec(0, 0, 0, 0, 0, 0);
    f1_brpos_i = 0; f1_brtyp_i = 0; f1_brpc_i = 0; f1_brtar_i = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_ready", rt_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_outs", {btb_sp_we_o, btb_rt_we_o, f1_drop_o, btb_ras_ctl_o, btb_sp_brpc_o == 0}, 6'b000001);
    reset = 0;

    // Taken conditional miss: allocate then direction one cycle later.
    push_one(64'h1000, 2'b00, 1, 0, 0);
    watch(5, 64'h1000);
    chk("t1_sp_tick", w_first_sp, 2);
    chk("t1_rt_tick", w_first_rt, 3);
    chk("t1_counts", {w_nsp[3:0], w_nrt[3:0]}, 8'h11);
    chk("t1_brdir", w_dir, 1);
    chk("t1_empty", empty_o, 1);

    push_one(64'h1100, 2'b00, 0, 1, 0);
    watch(4, 64'h1100);
    chk("t2_rt_tick", w_first_rt, 2);
    chk("t2_nsp", w_nsp, 0);
    chk("t2_brdir", w_dir, 0);
    push_one(64'h1200, 2'b00, 0, 0, 0);
    watch(4, 64'h1200);
    chk("t2_silent", w_nsp + w_nrt, 0);

    push_one(64'h1300, 2'b10, 1, 0, 0);
    watch(4, 64'h1300);
    chk("t3_call_tick", w_first_sp, 2);
    chk("t3_call_ras", w_ras, 2'b01);
    chk("t3_call_nrt", w_nrt, 0);
    push_one(64'h1400, 2'b11, 1, 1, 1);
    watch(4, 64'h1400);
    chk("t3_ret_ras", w_ras, 2'b10);

    // Starvation: queued call miss against continuous fetch1 writes.
    f1_we_i = 1; f1_brpc_i = 64'hF1F1; f1_brtar_i = 64'hF2F2; f1_brtyp_i = 2'b01;
    push_one(64'h1500, 2'b10, 1, 0, 0);
    watch(12, 64'h1500);
    chk("t4_win_tick", w_tgt, 10);
    chk("t4_ndrop", w_ndrop, 1);

    // Full FIFO while fetch1 holds the allocate port.
    for (int i = 0; i < 4; i++) push_one(64'hA0 + 64'(i), 2'b01, 1, 0, 0);
    chk("t5_full_ready", rt_ready_o, 0);
    push_one(64'hBAD, 2'b01, 1, 0, 0);
    f1_we_i = 0;
    watch(30, 64'hA0);
    chk("t5_nsp", w_nsp, 4);
    for (int i = 0; i < 4; i++) chk("t5_order", w_seen[i], 64'hA0 + 64'(i));
    chk("t5_ready_back", rt_ready_o, 1);

    // Reset while a queued allocation is starving.
    f1_we_i = 1;
    for (int i = 0; i < 3; i++) push_one(64'hC0 + 64'(i), 2'b10, 1, 0, 0);
    tick(); tick();
    #2 reset = 1;
    #1;
    chk("t6_rst_outs", {btb_sp_we_o, btb_rt_we_o, btb_ras_ctl_o, btb_sp_brpc_o == 0, btb_rt_brpc_o == 0}, 6'b000011);
    chk("t6_rst_empty", {empty_o, rt_ready_o}, 2'b11);
    model_reset();
    f1_we_i = 0;
    @(negedge clock);
    reset = 0;
    watch(6, 64'hC0);
    chk("t6_no_writes", w_nsp + w_nrt, 0);

    // Random traffic at three fetch1 pressure levels.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 700; i++) begin
        rand_f1(p == 0 ? 10 : (p == 1 ? 50 : 95));
        set_rec({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom));
        rt_valid_i = ($urandom_range(0, 99) < 60);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/btb_upd_queue.md
Name: btb_upd_queue

Overview:
- Write-side companion of the 4-way branch target buffer.
- Accepts resolved branches from retire through a valid/ready handshake and buffers them in a small FIFO.
- Converts each buffered branch into BTB allocate writes (speculative/allocate port) and direction writes (retire port).
- Arbitrates the allocate port against fetch1 predecode writes, with starvation protection for queued allocations.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- STARVE_MAX, 8, consecutive lost-arbitration cycles before a queued allocation forcibly wins the allocate port.

Ports:
- clock  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- rt_valid_i  input  1  retired-branch record valid
- rt_ready_o  output  1  queue can accept a record
- rt_brpc_i  input  64  branch bundle PC
- rt_brtar_i  input  64  resolved target
- rt_brtyp_i  input  2  00 cond, 01 uncond direct, 10 call, 11 return
- rt_brpos_i  input  3  slot in fetch bundle
- rt_taken_i  input  1  resolved direction
- rt_btbhit_i  input  1  BTB hit at prediction time
- rt_tarmis_i  input  1  predicted target differed from resolved target
- f1_we_i  input  1  fetch1 predecode write request
- f1_brpos_i  input  3  fetch1 write: slot in fetch bundle
- f1_brtyp_i  input  2  fetch1 write: branch type
- f1_brpc_i  input  64  fetch1 write: branch PC
- f1_brtar_i  input  64  fetch1 write: branch target
- f1_drop_o  output  1  pulses when an f1 write is discarded by a starvation override
- btb_sp_we_o  output  1  BTB allocate-port write enable
- btb_sp_brpos_o  output  3  allocate-port slot in fetch bundle
- btb_sp_brtyp_o  output  2  allocate-port branch type
- btb_sp_brpc_o  output  64  allocate-port branch PC
- btb_sp_brtar_o  output  64  allocate-port branch target
- btb_ras_ctl_o  output  2  RAS control for the allocate write: 01 push, 10 pop, 00 none
- btb_rt_we_o  output  1  BTB direction-port write enable
- btb_rt_brdir_o  output  1  direction-port branch direction
- btb_rt_brpc_o  output  64  direction-port branch PC
- empty_o  output  1  FIFO empty

Behaviour:
- Reset:
  - All outputs 0 except empty_o=1 and rt_ready_o=1.
  - FIFO count 0, state IDLE, starvation counter 0.
  - Reset mid-operation discards all queued records and any in-flight write.
- Push: when rt_valid_i && rt_ready_o, the record is written at the tail.
- rt_ready_o = (count != DEPTH). It is held low when full even if a pop occurs the same cycle.
- Simultaneous push and pop when not full leaves count unchanged.
- Head classification:
  - need_alloc = taken && (!btbhit || tarmis).
  - need_dir = (typ==00) && (btbhit || need_alloc).
- State machine (IDLE, ALLOC, DIR):
  - IDLE with FIFO non-empty: need_alloc -> ALLOC; else need_dir -> DIR; else pop the head silently (the cycle consumes the head, next cycle remains IDLE).
  - ALLOC, when granted the allocate port: register the allocate write from the head. Then go to DIR if typ==00; otherwise pop and go to IDLE.
  - DIR: register btb_rt_we_o=1, brdir=taken, brpc=head PC. Pop and go to IDLE.
- Latency: all btb_* outputs are registered, so every write appears the cycle after the grant/decision. The sp enable and rt enable are each 1-cycle pulses.
- Ordering: the direction write for an allocated conditional branch always lands exactly 1 cycle after its allocate write.
- Allocate-port arbitration:
  - f1_we_i has priority, and its fields are registered onto btb_sp_* with the same 1-cycle latency.
  - Each ALLOC cycle lost to f1 increments the starvation counter.
  - When the counter reaches STARVE_MAX, the next ALLOC cycle wins even if f1_we_i=1. That f1 request is dropped and f1_drop_o=1 for that cycle.
  - The counter clears on any ALLOC grant and whenever the state is not ALLOC.
- RAS control: btb_ras_ctl_o = 01 for typ 10, 10 for typ 11, 00 otherwise. It is computed from whichever source owns the allocate port.
- Idle port values: btb_sp_we_o=0 and btb_rt_we_o=0. Data outputs hold their last value.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- empty_o = (count==0), registered from count.

Test Plan:
- Miss, taken cond: push {pc=0x1000, tar=0x2000, typ=00, taken=1, hit=0} -> sp_we pulse with brpc 0x1000, brtar 0x2000, ras 00, then rt_we pulse 1 cycle later with brdir=1, pc 0x1000; empty_o=1 afterward.
- Hit, not-taken cond: push {hit=1, taken=0, tarmis=0} -> no sp_we; single rt_we with brdir=0; untaken-miss cond record is popped with no writes.
- Call and return misses: call, typ=10 miss -> sp_we with ras_ctl=01 and no rt_we; return, typ=11 with tarmis=1 -> sp_we with ras_ctl=10.
- Full FIFO: with f1_we_i held at 1, push 4 records -> rt_ready_o=0 after the 4th; a 5th valid is not accepted. Release f1 -> all 4 drain in order and ready returns.
- Starvation: one miss queued, f1_we_i=1 continuously -> 8 cycles of f1 writes, then the queued write wins with f1_drop_o=1 for exactly 1 cycle; the counter restarts at 0.
- Reset asserted while in ALLOC with 3 records queued -> all outputs 0, empty_o=1 immediately; no write appears after reset deasserts.
